// File: rtl/writeback_stage.sv
// Final pipeline stage: commits exec results to the register file, selects the next PC,
// and queues console bytes in a small FIFO drained over a valid/ready stream.
module writeback_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [3:0]  wselector,
    input  logic [31:0] data,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_cur,
    output logic        done,
    output logic        busy,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic [31:0] pc_next,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [7:0]       stall_byte;

    logic       pop;
    logic       free;
    logic       push_req;
    logic       push;
    logic [7:0] push_byte;

    logic unused_bits;
    assign unused_bits = ^{wselector[0], pc_in[1:0]};

    assign tx_valid = (count != '0);
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    // A slot freed by a same-cycle pop is usable, so a full FIFO can still accept.
    assign free     = (count < DEPTH_C) || pop;

    always_comb begin
        push_req  = 1'b0;
        push_byte = stall_byte;
        if (state == STALL) begin
            push_req = 1'b1;
        end else if (enable && wselector[3]) begin
            push_req  = 1'b1;
            push_byte = data[7:0];
        end
    end

    assign push = push_req && free;

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            reg_we     <= 1'b0;
            reg_waddr  <= '0;
            reg_wdata  <= '0;
            pc_next    <= RESET_PC;
            stall_byte <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            reg_we <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        if (wselector[1] && (rd_in != 5'd0)) begin
                            reg_we    <= 1'b1;
                            reg_waddr <= rd_in;
                            reg_wdata <= data;
                        end
                        pc_next <= wselector[2] ? {pc_in[31:2], 2'b00} : pc_cur + 32'd4;
                        if (wselector[3] && !free) begin
                            stall_byte <= data[7:0];
                            busy       <= 1'b1;
                            state      <= STALL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (free) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: direct checks on commit outputs plus a
// byte scoreboard filled on OUT commits and drained as the FIFO pops.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [3:0]  wselector;
    logic [31:0] data;
    logic [4:0]  rd_in;
    logic [31:0] pc_in;
    logic [31:0] pc_cur;
    logic        done;
    logic        busy;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] pc_next;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  sb [$];

    always #5 clk = ~clk;

    writeback_stage #(
        .RESET_PC  (32'h100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .wselector(wselector),
        .data     (data),
        .rd_in    (rd_in),
        .pc_in    (pc_in),
        .pc_cur   (pc_cur),
        .done     (done),
        .busy     (busy),
        .reg_we   (reg_we),
        .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata),
        .pc_next  (pc_next),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drives one result pulse; returns 1 time unit after the capturing edge.
    task automatic commit(input logic [3:0] ws, input logic [4:0] rd,
                          input logic [31:0] d, input logic [31:0] pi, input logic [31:0] pc);
        enable    = 1'b1;
        wselector = ws;
        rd_in     = rd;
        data      = d;
        pc_in     = pi;
        pc_cur    = pc;
        if (ws[3]) sb.push_back(d[7:0]);
        @(posedge clk);
        #1;
        enable    = 1'b0;
        wselector = 4'd0;
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!tx_valid) break;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    always @(posedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 32'd1);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; enable = 1'b0; wselector = '0; data = '0;
        rd_in = '0; pc_in = '0; pc_cur = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_next", pc_next, 32'h100);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;

        commit(4'b0010, 5'd5, 32'hDEADBEEF, 32'h0, 32'h40);
        check("rw_we", 32'(reg_we), 32'd1);
        check("rw_waddr", 32'(reg_waddr), 32'd5);
        check("rw_wdata", reg_wdata, 32'hDEADBEEF);
        check("rw_pc", pc_next, 32'h44);
        check("rw_done", 32'(done), 32'd1);
        commit(4'b0010, 5'd0, 32'h12345678, 32'h0, 32'h44);
        check("r0_we", 32'(reg_we), 32'd0);
        check("r0_done", 32'(done), 32'd1);
        check("r0_pc", pc_next, 32'h48);

        commit(4'b0110, 5'd31, 32'h48, 32'h203, 32'h44);
        check("jal_we", 32'(reg_we), 32'd1);
        check("jal_waddr", 32'(reg_waddr), 32'd31);
        check("jal_wdata", reg_wdata, 32'h48);
        check("jal_pc", pc_next, 32'h200);

        commit(4'b0000, 5'd3, 32'h0, 32'h0, 32'hFFFFFFFC);
        check("wrap_pc", pc_next, 32'h0);
        check("wrap_we", 32'(reg_we), 32'd0);
        check("wrap_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);

        commit(4'b1000, 5'd0, 32'h141, 32'h0, 32'h10);
        commit(4'b1000, 5'd0, 32'h42,  32'h0, 32'h14);
        commit(4'b1000, 5'd0, 32'h43,  32'h0, 32'h18);
        commit(4'b1000, 5'd0, 32'h44,  32'h0, 32'h1C);
        check("full_done", 32'(done), 32'd1);
        check("full_head", 32'(tx_data), 32'h41);
        check("full_valid", 32'(tx_valid), 32'd1);
        commit(4'b1000, 5'd0, 32'h45, 32'h0, 32'h20);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_done", 32'(done), 32'd0);
        check("stall_pc", pc_next, 32'h24);
        @(posedge clk);
        #1;
        check("stall_hold", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("unstall_done", 32'(done), 32'd1);
        check("unstall_busy", 32'(busy), 32'd0);
        check("unstall_head", 32'(tx_data), 32'h42);
        drain("drain4");

        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            commit(4'b1000, 5'd0, 32'(8'h60 + i), 32'h0, 32'(32'h300 + 4 * i));
            check("stream_done", 32'(done), 32'd1);
        end
        drain("stream");

        for (int i = 0; i < 5; i++) begin
            commit(4'b1000, 5'd0, 32'(8'hA0 + i), 32'h0, 32'h400);
        end
        check("rs_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_tx_valid", 32'(tx_valid), 32'd0);
        check("rs_pc", pc_next, 32'h100);
        rstn = 1'b1;
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rs_quiet", 32'(tx_valid), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        tx_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
